// File: rtl/core_ldst_single_ctrl_if.sv
// ============================================================================
//  Module      : core_ldst_single_ctrl_if
//  Description : Data-bus interface between the load/store sequencer and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_ldst_single_ctrl_if;
    logic        bus_start;
    logic [29:0] bus_addr;
    logic        bus_write;
    logic [31:0] bus_data_wr;
    logic [3:0]  bus_byteenable;
    logic        bus_user;
    logic        bus_ready;
    logic        bus_fault;
    logic [31:0] bus_data_rd;

    modport master (
        output bus_start, bus_addr, bus_write, bus_data_wr, bus_byteenable, bus_user,
        input  bus_ready, bus_fault, bus_data_rd
    );

    modport slave (
        input  bus_start, bus_addr, bus_write, bus_data_wr, bus_byteenable, bus_user,
        output bus_ready, bus_fault, bus_data_rd
    );
endinterface

`default_nettype wire

// File: rtl/core_ldst_single_ctrl.sv
// ============================================================================
//  Module      : core_ldst_single_ctrl
//  Description : Single-register LDR/STR/LDRB/STRB sequencer: one bus access,
//                then base and Rd writebacks through one register-file port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_ldst_single_ctrl (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           load,
    // "byte" is a reserved word in SystemVerilog
    input  logic                           byte_access,
    input  logic                           increment,
    input  logic                           pre_indexed,
    input  logic                           writeback,
    input  logic                           unprivileged,
    input  logic [3:0]                     rn,
    input  logic [3:0]                     rd,
    input  logic [31:0]                    base,
    input  logic [31:0]                    offset,
    input  logic [31:0]                    st_data,
    output logic                           busy,
    output logic                           done,
    output logic                           abort,
    core_ldst_single_ctrl_if.master        bus,
    output logic                           wr_enable,
    output logic [3:0]                     wr_index,
    output logic [31:0]                    wr_value
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_WB_BASE = 3'd3,
        S_WB_RD   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_load;
    logic        r_byte;
    logic        r_writeback;
    logic        r_user;
    logic [3:0]  r_rn;
    logic [3:0]  r_rd;
    logic [31:0] r_new_base;
    logic [31:0] r_addr;
    logic [31:0] r_st_data;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic [31:0] w_new_base;
    logic        w_bus_active;
    logic [31:0] w_load_data;

    assign w_new_base = increment ? (base + offset) : (base - offset);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_load      <= 1'b0;
            r_byte      <= 1'b0;
            r_writeback <= 1'b0;
            r_user      <= 1'b0;
            r_rn        <= 4'd0;
            r_rd        <= 4'd0;
            r_new_base  <= 32'd0;
            r_addr      <= 32'd0;
            r_st_data   <= 32'd0;
            r_rdata     <= 32'd0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && start) begin
                r_load      <= load;
                r_byte      <= byte_access;
                r_writeback <= writeback;
                r_user      <= unprivileged;
                r_rn        <= rn;
                r_rd        <= rd;
                r_new_base  <= w_new_base;
                r_addr      <= pre_indexed ? w_new_base : base;
                r_st_data   <= st_data;
                r_fault     <= 1'b0;
            end
            if (r_state == S_WAIT && bus.bus_ready) begin
                r_rdata <= bus.bus_data_rd;
                r_fault <= bus.bus_fault;
            end
        end
    end

    // Word loads rotate unaligned data right by the byte offset (ARMv4 behaviour)
    always_comb begin
        w_load_data = 32'd0;
        if (r_byte) begin
            w_load_data = {24'd0, r_rdata[{r_addr[1:0], 3'b000} +: 8]};
        end else begin
            case (r_addr[1:0])
                2'd0:    w_load_data = r_rdata;
                2'd1:    w_load_data = {r_rdata[7:0],  r_rdata[31:8]};
                2'd2:    w_load_data = {r_rdata[15:0], r_rdata[31:16]};
                default: w_load_data = {r_rdata[23:0], r_rdata[31:24]};
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        wr_enable    = 1'b0;
        wr_index     = 4'd0;
        wr_value     = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.bus_ready) begin
                    if (bus.bus_fault) begin
                        w_state_next = S_DONE;
                    end else if (r_writeback) begin
                        w_state_next = S_WB_BASE;
                    end else if (r_load) begin
                        w_state_next = S_WB_RD;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_WB_BASE: begin
                wr_enable    = 1'b1;
                wr_index     = r_rn;
                wr_value     = r_new_base;
                w_state_next = r_load ? S_WB_RD : S_DONE;
            end
            S_WB_RD: begin
                wr_enable    = 1'b1;
                wr_index     = r_rd;
                wr_value     = w_load_data;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign abort = (r_state == S_DONE) && r_fault;

    assign w_bus_active       = (r_state == S_REQ) || (r_state == S_WAIT);
    assign bus.bus_start      = (r_state == S_REQ);
    assign bus.bus_addr       = w_bus_active ? r_addr[31:2] : 30'd0;
    assign bus.bus_write      = w_bus_active && !r_load;
    assign bus.bus_user       = w_bus_active && r_user;
    assign bus.bus_byteenable = !w_bus_active ? 4'b0000 :
                                r_byte ? (4'b0001 << r_addr[1:0]) : 4'b1111;
    assign bus.bus_data_wr    = !w_bus_active ? 32'd0 :
                                r_byte ? {4{r_st_data[7:0]}} : r_st_data;

endmodule

`default_nettype wire

// File: tb/tb_core_ldst_single_ctrl.sv
// ============================================================================
//  Module      : tb_core_ldst_single_ctrl
//  Description : Directed self-checking bench with a register-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_ldst_single_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        load;
    logic        byte_access;
    logic        increment;
    logic        pre_indexed;
    logic        writeback;
    logic        unprivileged;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] st_data;
    logic        busy;
    logic        done;
    logic        abort;
    logic        wr_enable;
    logic [3:0]  wr_index;
    logic [31:0] wr_value;

    int checks = 0;
    int errors = 0;

    // Expected register writes as {index, value}
    logic [35:0] exp_q[$];

    core_ldst_single_ctrl_if bus_if ();

    core_ldst_single_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .load         (load),
        .byte_access  (byte_access),
        .increment    (increment),
        .pre_indexed  (pre_indexed),
        .writeback    (writeback),
        .unprivileged (unprivileged),
        .rn           (rn),
        .rd           (rd),
        .base         (base),
        .offset       (offset),
        .st_data      (st_data),
        .busy         (busy),
        .done         (done),
        .abort        (abort),
        .bus          (bus_if),
        .wr_enable    (wr_enable),
        .wr_index     (wr_index),
        .wr_value     (wr_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wr_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {28'd0, wr_index, wr_value}, 64'd0);
            end else begin
                chk("reg_write", {28'd0, wr_index, wr_value}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive_req(input logic ld, input logic b, input logic inc, input logic pre,
                             input logic wb, input logic usr, input logic [3:0] rn_i,
                             input logic [3:0] rd_i, input logic [31:0] base_i,
                             input logic [31:0] off_i, input logic [31:0] st_i);
        load = ld; byte_access = b; increment = inc; pre_indexed = pre;
        writeback = wb; unprivileged = usr; rn = rn_i; rd = rd_i;
        base = base_i; offset = off_i; st_data = st_i;
    endtask

    task automatic run_op(input string name, input int delay, input logic flt,
                          input logic [31:0] rdata, input logic [29:0] e_addr,
                          input logic [3:0] e_be, input logic e_write,
                          input logic [31:0] e_wdata, input logic e_user,
                          input int e_done, input logic e_abort, input logic poke);
        int s = -1;
        bit seen = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            bus_if.bus_ready = 1'b0;
            bus_if.bus_fault = 1'b0;
            if (poke && s >= 0 && cyc == s + 2) start = 1'b0;
            if (bus_if.bus_start === 1'b1) begin
                s = cyc;
                chk({name, "_start_cycle"}, cyc, 1);
                chk({name, "_addr"}, bus_if.bus_addr, e_addr);
                chk({name, "_be"}, bus_if.bus_byteenable, e_be);
                chk({name, "_write"}, bus_if.bus_write, e_write);
                chk({name, "_user"}, bus_if.bus_user, e_user);
                if (e_write) chk({name, "_wdata"}, bus_if.bus_data_wr, e_wdata);
            end
            if (s >= 0 && cyc == s + 1) begin
                chk({name, "_addr_hold"}, bus_if.bus_addr, e_addr);
                if (poke) start = 1'b1;
            end
            if (s >= 0 && cyc == s + 1 + delay) begin
                bus_if.bus_ready   = 1'b1;
                bus_if.bus_fault   = flt;
                bus_if.bus_data_rd = rdata;
            end
            if (done === 1'b1) begin
                seen = 1;
                chk({name, "_done_cycle"}, cyc, e_done);
                chk({name, "_abort"}, abort, e_abort);
                break;
            end
        end
        if (!seen) chk({name, "_done_timeout"}, 0, 1);
        start = 1'b0;
        @(negedge clk);
        chk({name, "_idle_after"}, {busy, done, abort}, 3'b000);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        drive_req(0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
        bus_if.bus_ready = 1'b0; bus_if.bus_fault = 1'b0; bus_if.bus_data_rd = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_status", {busy, done, abort, wr_enable}, 4'b0000);
        chk("reset_bus", {bus_if.bus_start, bus_if.bus_write, bus_if.bus_user,
                          bus_if.bus_addr, bus_if.bus_byteenable}, 37'd0);
        chk("reset_bus_data", bus_if.bus_data_wr, 32'd0);
        chk("reset_wr", {wr_index, wr_value}, 36'd0);
        rst = 1'b0;
        @(negedge clk);

        // LDR pre-indexed with writeback
        drive_req(1, 0, 1, 1, 1, 0, 4'd1, 4'd2, 32'h1000, 32'd4, 32'd0);
        exp_q.push_back({4'd1, 32'h0000_1004});
        exp_q.push_back({4'd2, 32'hDEAD_BEEF});
        run_op("ldr_pre_wb", 0, 0, 32'hDEAD_BEEF, 30'h401, 4'b1111, 0, 32'd0, 0, 5, 0, 0);

        // LDRB post-indexed decrement
        drive_req(1, 1, 0, 0, 1, 0, 4'd3, 4'd4, 32'h2003, 32'd3, 32'd0);
        exp_q.push_back({4'd3, 32'h0000_2000});
        exp_q.push_back({4'd4, 32'h0000_00AA});
        run_op("ldrb_post", 0, 0, 32'hAABB_CCDD, 30'h800, 4'b1000, 0, 32'd0, 0, 5, 0, 0);

        // STRB (T-variant) without writeback
        drive_req(0, 1, 1, 1, 0, 1, 4'd5, 4'd6, 32'h3001, 32'd0, 32'h1234_5678);
        run_op("strb", 0, 0, 32'd0, 30'hC00, 4'b0010, 1, 32'h7878_7878, 1, 3, 0, 0);

        // Unaligned LDR: word rotated right by 16
        drive_req(1, 0, 1, 1, 0, 0, 4'd9, 4'd5, 32'h4000, 32'd2, 32'd0);
        exp_q.push_back({4'd5, 32'h3344_1122});
        run_op("ldr_unaligned", 0, 0, 32'h1122_3344, 30'h1000, 4'b1111, 0, 32'd0, 0, 4, 0, 0);

        // Faulting LDR with writeback; start pulsed during WAIT must be ignored
        drive_req(1, 0, 1, 1, 1, 0, 4'd1, 4'd2, 32'h5000, 32'd8, 32'd0);
        run_op("ldr_fault", 3, 1, 32'h5555_5555, 30'h1402, 4'b1111, 0, 32'd0, 0, 6, 1, 1);

        // STR word, pre-indexed decrement with writeback
        drive_req(0, 0, 0, 1, 1, 0, 4'd7, 4'd3, 32'h6000, 32'h10, 32'hCAFE_F00D);
        exp_q.push_back({4'd7, 32'h0000_5FF0});
        run_op("str_wb", 1, 0, 32'd0, 30'h17FC, 4'b1111, 1, 32'hCAFE_F00D, 0, 5, 0, 0);

        // rd == rn: loaded value written last
        drive_req(1, 0, 1, 1, 1, 0, 4'd8, 4'd8, 32'h7000, 32'd4, 32'd0);
        exp_q.push_back({4'd8, 32'h0000_7004});
        exp_q.push_back({4'd8, 32'h0000_0055});
        run_op("ldr_rd_eq_rn", 0, 0, 32'h0000_0055, 30'h1C01, 4'b1111, 0, 32'd0, 0, 5, 0, 0);

        // Reset while in WAIT, then a late bus_ready
        drive_req(1, 0, 1, 1, 1, 0, 4'd2, 4'd3, 32'h8000, 32'd4, 32'd0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_busy_wait", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.bus_ready = 1'b1;
        bus_if.bus_data_rd = 32'h0BAD_0BAD;
        chk("rst_mid_idle", {busy, done}, 2'b00);
        @(negedge clk);
        bus_if.bus_ready = 1'b0;
        chk("rst_late_ready_idle", {busy, done, wr_enable}, 3'b000);
        @(negedge clk);
        chk("rst_late_ready_idle2", {busy, done, wr_enable}, 3'b000);

        // Fresh transfer completes normally after the reset
        drive_req(1, 0, 1, 1, 1, 0, 4'd2, 4'd3, 32'h8000, 32'd4, 32'd0);
        exp_q.push_back({4'd2, 32'h0000_8004});
        exp_q.push_back({4'd3, 32'h1357_9BDF});
        run_op("ldr_after_rst", 0, 0, 32'h1357_9BDF, 30'h2001, 4'b1111, 0, 32'd0, 0, 5, 0, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
